// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// The winning-write helper resolves write-port collisions for a single entry.
package reg_file_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 3;
    localparam int DEF_NUM_WR = 2;
    localparam int ZERO_IDX   = 0;

    // Helper operates on port vectors padded to these maxima.
    localparam int MAX_WR     = 8;
    localparam int MAX_ADDR_W = 16;
    localparam int WR_IDX_W   = 3;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] port;
    } wr_win_t;

    // Highest-index enabled port addressing 'entry' wins.
    function automatic wr_win_t win_write_port(
        input logic [MAX_WR-1:0]            en,
        input logic [MAX_WR*MAX_ADDR_W-1:0] addrs,
        input logic [MAX_ADDR_W-1:0]        entry
    );
        wr_win_t res;
        res = '0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (en[i] && (addrs[i*MAX_ADDR_W +: MAX_ADDR_W] == entry)) begin
                res.hit  = 1'b1;
                res.port = WR_IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: entry select, range and zero-entry masking,
// optional bypass of same-cycle writes, and output registers.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read_en,
    input  logic [ADDR_W-1:0]       read_addr,
    input  logic [DEPTH*DATA_W-1:0] cur_data,
    input  logic [DEPTH-1:0]        cur_pend,
    input  logic [DEPTH*DATA_W-1:0] nxt_data,
    input  logic [DEPTH-1:0]        nxt_pend,
    output logic [DATA_W-1:0]       read_data,
    output logic                    read_valid,
    output logic                    read_pending
);

    logic [DEPTH*DATA_W-1:0] src_data_s;
    logic [DEPTH-1:0]        src_pend_s;
    logic                    in_range_s;
    logic                    is_zero_s;
    logic                    rd_ok_s;
    logic [DATA_W-1:0]       raw_data_s;
    logic                    raw_pend_s;

    // Bypass reads the resolved post-edge state instead of current contents.
    assign src_data_s = (BYPASS != 0) ? nxt_data : cur_data;
    assign src_pend_s = (BYPASS != 0) ? nxt_pend : cur_pend;

    assign in_range_s = ({1'b0, read_addr} < (ADDR_W+1)'(DEPTH));
    assign is_zero_s  = (ZERO_REG != 0) && (read_addr == ADDR_W'(ZERO_IDX));
    assign rd_ok_s    = in_range_s && !is_zero_s;

    // One-hot AND-OR entry select; no match yields zero.
    always_comb begin
        raw_data_s = '0;
        raw_pend_s = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            raw_data_s = raw_data_s |
                ({DATA_W{read_addr == ADDR_W'(e)}} & src_data_s[e*DATA_W +: DATA_W]);
            raw_pend_s = raw_pend_s | ((read_addr == ADDR_W'(e)) & src_pend_s[e]);
        end
    end

    // Output registers: capture on read_en, otherwise hold with valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data    <= '0;
            read_pending <= 1'b0;
            read_valid   <= 1'b0;
        end else if (read_en) begin
            read_data    <= rd_ok_s ? raw_data_s : '0;
            read_pending <= rd_ok_s ? raw_pend_s : 1'b0;
            read_valid   <= 1'b1;
        end else begin
            read_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with per-entry pending bits, clocked writes,
// registered reads, optional write-to-read bypass and a hardwired zero entry.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        read_en,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_valid,
    output logic [NUM_RD-1:0]        read_pending,
    input  logic [NUM_WR-1:0]        write_en,
    input  logic [NUM_WR*ADDR_W-1:0] write_addr,
    input  logic [NUM_WR*DATA_W-1:0] write_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    logic [MAX_WR-1:0]            wen_ext_s;
    logic [MAX_WR*MAX_ADDR_W-1:0] waddr_ext_s;
    logic [DEPTH*DATA_W-1:0]      cur_data_s;
    logic [DEPTH-1:0]             cur_pend_s;
    logic [DEPTH*DATA_W-1:0]      nxt_data_s;
    logic [DEPTH-1:0]             nxt_pend_s;

    // Pad write ports to the helper's fixed widths.
    always_comb begin
        wen_ext_s   = '0;
        waddr_ext_s = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wen_ext_s[i] = write_en[i];
            waddr_ext_s[i*MAX_ADDR_W +: MAX_ADDR_W] =
                MAX_ADDR_W'(write_addr[i*ADDR_W +: ADDR_W]);
        end
    end

    // Out-of-range addresses match no entry, so they are dropped naturally.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam bit LIVE = !((ZERO_REG != 0) && (e == ZERO_IDX));

        wr_win_t           win_s;
        logic              rsv_hit_s;
        logic [DATA_W-1:0] wdata_s;
        logic [DATA_W-1:0] nxt_d_s;
        logic              nxt_p_s;
        logic [DATA_W-1:0] data_r;
        logic              pend_r;

        assign win_s     = win_write_port(wen_ext_s, waddr_ext_s, MAX_ADDR_W'(e));
        assign rsv_hit_s = rsv_en && (rsv_addr == ADDR_W'(e));

        // Mux the winning port's data.
        always_comb begin
            wdata_s = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                wdata_s = wdata_s |
                    ({DATA_W{win_s.port == WR_IDX_W'(i)}} & write_data[i*DATA_W +: DATA_W]);
            end
        end

        // A reservation beats a same-cycle write on the pending bit.
        always_comb begin
            if (!LIVE) begin
                nxt_d_s = '0;
                nxt_p_s = 1'b0;
            end else if (win_s.hit) begin
                nxt_d_s = wdata_s;
                nxt_p_s = rsv_hit_s;
            end else begin
                nxt_d_s = data_r;
                nxt_p_s = pend_r | rsv_hit_s;
            end
        end

        // Entry storage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_r <= '0;
                pend_r <= 1'b0;
            end else begin
                data_r <= nxt_d_s;
                pend_r <= nxt_p_s;
            end
        end

        assign cur_data_s[e*DATA_W +: DATA_W] = data_r;
        assign cur_pend_s[e]                  = pend_r;
        assign nxt_data_s[e*DATA_W +: DATA_W] = nxt_d_s;
        assign nxt_pend_s[e]                  = nxt_p_s;
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk          (clk),
            .rst_n        (rst_n),
            .read_en      (read_en[j]),
            .read_addr    (read_addr[j*ADDR_W +: ADDR_W]),
            .cur_data     (cur_data_s),
            .cur_pend     (cur_pend_s),
            .nxt_data     (nxt_data_s),
            .nxt_pend     (nxt_pend_s),
            .read_data    (read_data[j*DATA_W +: DATA_W]),
            .read_valid   (read_valid[j]),
            .read_pending (read_pending[j])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: two instances (DEPTH=20 with bypass, DEPTH=32 without)
// driven in lockstep, each checked against an array-based reference model.
module tb_reg_file_mp;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR-1:0]     read_en;
    logic [NR*AW-1:0]  read_addr;
    logic [NW-1:0]     write_en;
    logic [NW*AW-1:0]  write_addr;
    logic [NW*DW-1:0]  write_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;

    logic [NR*DW-1:0]  rdata  [2];
    logic [NR-1:0]     rvalid [2];
    logic [NR-1:0]     rpend  [2];

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20), .NUM_RD(NR), .NUM_WR(NW),
                  .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr),
        .read_data(rdata[0]), .read_valid(rvalid[0]), .read_pending(rpend[0]),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .NUM_RD(NR), .NUM_WR(NW),
                  .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .read_addr(read_addr),
        .read_data(rdata[1]), .read_valid(rvalid[1]), .read_pending(rpend[1]),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    int cfg_depth [2] = '{20, 32};
    bit cfg_byp   [2] = '{1'b1, 1'b0};

    logic [DW-1:0] m_data [2][32];
    logic          m_pend [2][32];

    typedef struct {
        int          inst;
        int          port;
        logic [DW-1:0] data;
        logic        pend;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] last_data [2][NR];
    logic          last_pend [2][NR];

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int e = 0; e < 32; e++) begin
                m_data[k][e] = 16'h0000;
                m_pend[k][e] = 1'b0;
            end
    endtask

    // One cycle of stimulus; expectations are derived from the model.
    task automatic step(input logic [NR-1:0] ren, input logic [NR*AW-1:0] raddr,
                        input logic [NW-1:0] wen, input logic [NW*AW-1:0] waddr,
                        input logic [NW*DW-1:0] wdata, input logic rsv,
                        input logic [AW-1:0] radr);
        logic [DW-1:0] n_data [32];
        logic          n_pend [32];
        exp_t          x;
        int            a;
        @(negedge clk);
        read_en = ren; read_addr = raddr;
        write_en = wen; write_addr = waddr; write_data = wdata;
        rsv_en = rsv; rsv_addr = radr;
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 32; e++) begin
                n_data[e] = m_data[k][e];
                n_pend[e] = m_pend[k][e];
            end
            for (int i = 0; i < NW; i++) begin
                a = int'(waddr[i*AW +: AW]);
                if (wen[i] && a < cfg_depth[k] && a != 0) begin
                    n_data[a] = wdata[i*DW +: DW];
                    n_pend[a] = 1'b0;
                end
            end
            a = int'(radr);
            if (rsv && a < cfg_depth[k] && a != 0) n_pend[a] = 1'b1;
            for (int j = 0; j < NR; j++) begin
                if (ren[j]) begin
                    a = int'(raddr[j*AW +: AW]);
                    x.inst = k;
                    x.port = j;
                    if (a >= cfg_depth[k] || a == 0) begin
                        x.data = 16'h0000;
                        x.pend = 1'b0;
                    end else if (cfg_byp[k]) begin
                        x.data = n_data[a];
                        x.pend = n_pend[a];
                    end else begin
                        x.data = m_data[k][a];
                        x.pend = m_pend[k][a];
                    end
                    exp_q.push_back(x);
                end
            end
            for (int e = 0; e < 32; e++) begin
                m_data[k][e] = n_data[e];
                m_pend[k][e] = n_pend[e];
            end
        end
    endtask

    task automatic idle();
        step(3'b000, 15'd0, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Monitor: pops expectations whenever a read port presents valid data.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < NR; j++) begin
                if (!rst_n) begin
                    checks++;
                    if (rvalid[k][j] !== 1'b0 || rpend[k][j] !== 1'b0 ||
                        rdata[k][j*DW +: DW] !== 16'h0000) begin
                        errors++;
                        $display("FAIL reset_out inst=%0d port=%0d valid=%b pend=%b data=%h required 0 0 0000",
                                 k, j, rvalid[k][j], rpend[k][j], rdata[k][j*DW +: DW]);
                    end
                    last_data[k][j] = 16'h0000;
                    last_pend[k][j] = 1'b0;
                end else if (rvalid[k][j] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid inst=%0d port=%0d got valid=1 required 0", k, j);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.inst != k || e.port != j) begin
                            errors++;
                            $display("FAIL valid_order got inst=%0d port=%0d required inst=%0d port=%0d",
                                     k, j, e.inst, e.port);
                        end else if (rdata[k][j*DW +: DW] !== e.data || rpend[k][j] !== e.pend) begin
                            errors++;
                            $display("FAIL read inst=%0d port=%0d got data=%h pend=%b required data=%h pend=%b",
                                     k, j, rdata[k][j*DW +: DW], rpend[k][j], e.data, e.pend);
                        end
                        last_data[k][j] = e.data;
                        last_pend[k][j] = e.pend;
                    end
                end else begin
                    checks++;
                    if (rdata[k][j*DW +: DW] !== last_data[k][j] || rpend[k][j] !== last_pend[k][j]) begin
                        errors++;
                        $display("FAIL hold inst=%0d port=%0d got data=%h pend=%b required data=%h pend=%b",
                                 k, j, rdata[k][j*DW +: DW], rpend[k][j], last_data[k][j], last_pend[k][j]);
                    end
                end
            end
        end
        if (!rst_n) exp_q.delete();
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NR*AW-1:0] ra;
        logic [NW*AW-1:0] wa;
        logic [AW-1:0]    hot;
        rst_n = 1'b0;
        read_en = '0; read_addr = '0; write_en = '0; write_addr = '0;
        write_data = '0; rsv_en = 1'b0; rsv_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset mid-cycle clears a written entry; reads requested in reset are ignored.
        step(3'b000, 15'd0, 2'b01, {5'd0, 5'd5}, {16'h0000, 16'hA5A5}, 1'b0, 5'd0);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        read_en = 3'b001; read_addr = {5'd0, 5'd0, 5'd5};
        @(posedge clk);
        @(posedge clk);
        #1 read_en = 3'b000;
        #1 rst_n = 1'b1;
        step(3'b001, {5'd0, 5'd0, 5'd5}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);
        idle();

        // Latency.
        step(3'b000, 15'd0, 2'b01, {5'd0, 5'd7}, {16'h0000, 16'h1234}, 1'b0, 5'd0);
        step(3'b001, {5'd0, 5'd0, 5'd7}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);
        idle();

        // Collision: port 1 wins; all read ports on the same entry.
        step(3'b000, 15'd0, 2'b11, {5'd9, 5'd9}, {16'h2222, 16'h1111}, 1'b0, 5'd0);
        step(3'b111, {5'd9, 5'd9, 5'd9}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);

        // Bypass versus pre-write value.
        step(3'b000, 15'd0, 2'b01, {5'd0, 5'd3}, {16'h0000, 16'h0001}, 1'b0, 5'd0);
        step(3'b001, {5'd0, 5'd0, 5'd3}, 2'b01, {5'd0, 5'd3}, {16'h0000, 16'h00FF}, 1'b0, 5'd0);
        step(3'b100, {5'd3, 5'd0, 5'd0}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);

        // Pending scoreboard.
        step(3'b000, 15'd0, 2'b00, 10'd0, 32'd0, 1'b1, 5'd12);
        step(3'b010, {5'd0, 5'd12, 5'd0}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);
        step(3'b000, 15'd0, 2'b10, {5'd12, 5'd0}, {16'h4444, 16'h0000}, 1'b0, 5'd0);
        step(3'b010, {5'd0, 5'd12, 5'd0}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);
        step(3'b000, 15'd0, 2'b01, {5'd0, 5'd12}, {16'h0000, 16'hBEEF}, 1'b1, 5'd12);
        step(3'b001, {5'd0, 5'd0, 5'd12}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);

        // Zero entry and out-of-range (25 is beyond DEPTH=20 only).
        step(3'b000, 15'd0, 2'b10, {5'd0, 5'd0}, {16'hFFFF, 16'h0000}, 1'b1, 5'd0);
        step(3'b111, {5'd0, 5'd0, 5'd0}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);
        step(3'b000, 15'd0, 2'b01, {5'd0, 5'd25}, {16'h0000, 16'h5A5A}, 1'b1, 5'd25);
        step(3'b111, {5'd19, 5'd25, 5'd5}, 2'b00, 10'd0, 32'd0, 1'b0, 5'd0);

        // Randomized traffic with a shared hot address to provoke collisions and bypass.
        for (int n = 0; n < 600; n++) begin
            hot = AW'($urandom_range(0, 31));
            for (int j = 0; j < NR; j++)
                ra[j*AW +: AW] = ($urandom_range(0, 2) == 0) ? hot : AW'($urandom_range(0, 31));
            for (int i = 0; i < NW; i++)
                wa[i*AW +: AW] = ($urandom_range(0, 1) == 0) ? hot : AW'($urandom_range(0, 31));
            step(NR'($urandom), ra, NW'($urandom), wa, $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 0) ? hot : AW'($urandom_range(0, 31)));
        end
        idle();
        idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_valid got %0d outstanding reads required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
